// File: rtl/odin_ctrl_pkg.sv
// Shared types and helpers for the event-sequencer control slice.
package odin_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        DONE = 3'd3,
        ACKW = 3'd4
    } seq_state_t;

    localparam logic EVT_SYN  = 1'b0;
    localparam logic EVT_TREF = 1'b1;

    // Synapse word address: pre-synaptic address plus the upper bits of the
    // post-synaptic index (eight synapses share one word).
    function automatic int synaddr_w(input int m);
        return 2 * m - 3;
    endfunction

endpackage

// File: rtl/aer_handshake_4ph.sv
// Four-phase req/ack front end: decides when an event may be taken and holds
// the acknowledge from sweep completion until the requester releases REQ.
module aer_handshake_4ph (
    input  logic clk_sys,
    input  logic rst_b,
    input  logic req,
    input  logic gate,
    input  logic idle,
    input  logic set_ack,
    input  logic in_ackw,
    output logic accept,
    output logic req_released,
    output logic ack
);

    // New work is only taken in IDLE; gating blocks acceptance, never a sweep.
    assign accept       = idle & req & ~gate;
    assign req_released = in_ackw & ~req;

    // ACK rises together with burst-end and falls on the edge that sees REQ low.
    always_ff @(posedge clk_sys) begin
        if (!rst_b) begin
            ack <= 1'b0;
        end else if (set_ack) begin
            ack <= 1'b1;
        end else if (req_released) begin
            ack <= 1'b0;
        end
    end

endmodule

// File: rtl/neur_event_sequencer.sv
// Sweeps every post-synaptic neuron for one incoming event with a read/write
// SRAM pair per neuron, then pulses burst-end and completes the handshake.
//
// state | meaning
// IDLE  | waiting for an ungated event request
// RD    | read cycle for neuron j (neuron SRAM, synapse word for synaptic events)
// WR    | write-back cycle for neuron j (synapse word only on last of eight, learning on)
// DONE  | one-cycle burst-end, acknowledge raised
// ACKW  | acknowledge held until the requester drops REQ
module neur_event_sequencer
    import odin_ctrl_pkg::*;
#(
    parameter int N = 256,
    parameter int M = 8
) (
    input  logic                      CLK,
    input  logic                      RSTN_syncn,
    input  logic                      SPI_GATE_ACTIVITY_sync,
    input  logic                      SPI_LEARN_EN,
    input  logic                      EVT_REQ,
    input  logic                      EVT_TYPE,
    input  logic [M-1:0]              EVT_ADDR,
    output logic                      EVT_ACK,
    output logic                      CTRL_SYNARRAY_CS,
    output logic                      CTRL_SYNARRAY_WE,
    output logic [synaddr_w(M)-1:0]   CTRL_SYNARRAY_ADDR,
    output logic                      CTRL_NEURMEM_CS,
    output logic                      CTRL_NEURMEM_WE,
    output logic [M-1:0]              CTRL_NEURMEM_ADDR,
    output logic                      CTRL_NEUR_EVENT,
    output logic                      CTRL_NEUR_TREF,
    output logic                      CTRL_NEUR_BURST_END,
    output logic                      BUSY
);

    localparam int           SAW    = synaddr_w(M);
    localparam logic [M-1:0] J_ONE  = M'(1);
    localparam logic [M-1:0] J_LAST = M'(N - 1);

    seq_state_t   state;
    logic [M-1:0] j;
    logic [M-1:0] j_next;
    logic [M-1:0] pre;
    logic         evt_type_q;
    logic         accept;
    logic         req_released;
    logic         set_ack;
    logic         syn_wb;

    function automatic logic [SAW-1:0] syn_word(input logic [M-1:0] pre_i,
                                                input logic [M-1:0] j_i);
        return {pre_i, j_i[M-1:3]};
    endfunction

    assign j_next  = j + J_ONE;
    assign set_ack = (state == WR) && (j == J_LAST);
    // Synapse word is written back once, after its eighth neuron has been processed.
    assign syn_wb  = (evt_type_q == EVT_SYN) && SPI_LEARN_EN && (j[2:0] == 3'b111);

    aer_handshake_4ph u_hs (
        .clk_sys      (CLK),
        .rst_b        (RSTN_syncn),
        .req          (EVT_REQ),
        .gate         (SPI_GATE_ACTIVITY_sync),
        .idle         (state == IDLE),
        .set_ack      (set_ack),
        .in_ackw      (state == ACKW),
        .accept       (accept),
        .req_released (req_released),
        .ack          (EVT_ACK)
    );

    // Sweep FSM; every output is registered with the state it belongs to.
    always_ff @(posedge CLK) begin
        if (!RSTN_syncn) begin
            state               <= IDLE;
            j                   <= '0;
            pre                 <= '0;
            evt_type_q          <= EVT_SYN;
            CTRL_SYNARRAY_CS    <= 1'b0;
            CTRL_SYNARRAY_WE    <= 1'b0;
            CTRL_SYNARRAY_ADDR  <= '0;
            CTRL_NEURMEM_CS     <= 1'b0;
            CTRL_NEURMEM_WE     <= 1'b0;
            CTRL_NEURMEM_ADDR   <= '0;
            CTRL_NEUR_EVENT     <= 1'b0;
            CTRL_NEUR_TREF      <= 1'b0;
            CTRL_NEUR_BURST_END <= 1'b0;
            BUSY                <= 1'b0;
        end else begin
            CTRL_SYNARRAY_CS    <= 1'b0;
            CTRL_SYNARRAY_WE    <= 1'b0;
            CTRL_NEURMEM_CS     <= 1'b0;
            CTRL_NEURMEM_WE     <= 1'b0;
            CTRL_NEUR_EVENT     <= 1'b0;
            CTRL_NEUR_TREF      <= 1'b0;
            CTRL_NEUR_BURST_END <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state              <= RD;
                        BUSY               <= 1'b1;
                        pre                <= EVT_ADDR;
                        evt_type_q         <= EVT_TYPE;
                        j                  <= '0;
                        CTRL_NEURMEM_CS    <= 1'b1;
                        CTRL_NEURMEM_ADDR  <= '0;
                        CTRL_SYNARRAY_ADDR <= syn_word(EVT_ADDR, '0);
                        CTRL_SYNARRAY_CS   <= (EVT_TYPE == EVT_SYN);
                        CTRL_NEUR_EVENT    <= (EVT_TYPE == EVT_SYN);
                        CTRL_NEUR_TREF     <= (EVT_TYPE == EVT_TREF);
                    end
                end
                RD: begin
                    state            <= WR;
                    CTRL_NEURMEM_CS  <= 1'b1;
                    CTRL_NEURMEM_WE  <= 1'b1;
                    CTRL_SYNARRAY_CS <= syn_wb;
                    CTRL_SYNARRAY_WE <= syn_wb;
                    CTRL_NEUR_EVENT  <= (evt_type_q == EVT_SYN);
                    CTRL_NEUR_TREF   <= (evt_type_q == EVT_TREF);
                end
                WR: begin
                    if (j == J_LAST) begin
                        state               <= DONE;
                        CTRL_NEUR_BURST_END <= 1'b1;
                    end else begin
                        state              <= RD;
                        j                  <= j_next;
                        CTRL_NEURMEM_CS    <= 1'b1;
                        CTRL_NEURMEM_ADDR  <= j_next;
                        CTRL_SYNARRAY_ADDR <= syn_word(pre, j_next);
                        CTRL_SYNARRAY_CS   <= (evt_type_q == EVT_SYN);
                        CTRL_NEUR_EVENT    <= (evt_type_q == EVT_SYN);
                        CTRL_NEUR_TREF     <= (evt_type_q == EVT_TREF);
                    end
                end
                DONE: begin
                    state <= ACKW;
                end
                ACKW: begin
                    if (req_released) begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neur_event_sequencer.sv
// Self-checking bench for neur_event_sequencer against a cycle-index model of
// one event sweep.
module tb_neur_event_sequencer;

    localparam int N = 256;
    localparam int M = 8;
    localparam int LAST_C = 2 * N + 1;   // sweep cycle index of burst-end

    logic        clk = 1'b0;
    logic        rstn;
    logic        gate;
    logic        learn;
    logic        req;
    logic        etype;
    logic [7:0]  eaddr;
    logic        ack;
    logic        syn_cs, syn_we;
    logic [12:0] syn_addr;
    logic        neur_cs, neur_we;
    logic [7:0]  neur_addr;
    logic        ev, tref, burst, busy;
    logic [29:0] obs;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    neur_event_sequencer #(.N(N), .M(M)) dut (
        .CLK                    (clk),
        .RSTN_syncn             (rstn),
        .SPI_GATE_ACTIVITY_sync (gate),
        .SPI_LEARN_EN           (learn),
        .EVT_REQ                (req),
        .EVT_TYPE               (etype),
        .EVT_ADDR               (eaddr),
        .EVT_ACK                (ack),
        .CTRL_SYNARRAY_CS       (syn_cs),
        .CTRL_SYNARRAY_WE       (syn_we),
        .CTRL_SYNARRAY_ADDR     (syn_addr),
        .CTRL_NEURMEM_CS        (neur_cs),
        .CTRL_NEURMEM_WE        (neur_we),
        .CTRL_NEURMEM_ADDR      (neur_addr),
        .CTRL_NEUR_EVENT        (ev),
        .CTRL_NEUR_TREF         (tref),
        .CTRL_NEUR_BURST_END    (burst),
        .BUSY                   (busy)
    );

    assign obs = {syn_cs, syn_we, syn_addr, neur_cs, neur_we, neur_addr,
                  ev, tref, burst, ack, busy};

    // Expected outputs at sweep cycle c (1 = first read after acceptance).
    // Odd cycles read neuron (c-1)/2, even cycles write it back.
    function automatic logic [29:0] model_out(int c, bit t, logic [7:0] p, bit l);
        int          jj;
        bit          wr, wb;
        logic        e_scs, e_swe;
        logic [12:0] e_sa;
        if (c >= 1 && c <= 2 * N) begin
            jj    = (c - 1) / 2;
            wr    = (c % 2) == 0;
            wb    = !t && l && ((jj % 8) == 7);
            e_scs = t ? 1'b0 : (wr ? wb : 1'b1);
            e_swe = wr && wb;
            e_sa  = {p, 5'(jj / 8)};
            return {e_scs, e_swe, e_sa, 1'b1, wr, 8'(jj), !t, t, 1'b0, 1'b0, 1'b1};
        end else if (c == LAST_C) begin
            return 30'h7;
        end
        return 30'h0;
    endfunction

    // Addresses only matter while a memory is being accessed.
    function automatic logic [29:0] care_mask(int c, bit t);
        logic [29:0] m;
        m = '1;
        if (c < 1 || c > 2 * N) begin
            m[27:15] = '0;
            m[12:5]  = '0;
        end
        if (t) m[27:15] = '0;
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_event(input bit t, input logic [7:0] p);
        etype = t;
        eaddr = p;
        req   = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; gate = 1'b0; learn = 1'b0; req = 1'b0; etype = 1'b0; eaddr = '0;
        repeat (3) tick();
        n_checks++;
        if (obs !== 30'h0) begin
            n_fail++; $display("FAIL reset_outputs got=%h exp=%h", obs, 30'h0);
        end
        rstn = 1'b1;
        repeat (2) tick();
        n_checks++;
        if (obs !== 30'h0) begin
            n_fail++; $display("FAIL reset_idle got=%h exp=%h", obs, 30'h0);
        end
    endtask

    task automatic test_syn_nolearn();
        logic [29:0] e, m;
        learn = 1'b0;
        start_event(1'b0, 8'h10);
        for (int c = 1; c <= LAST_C; c++) begin
            tick();
            e = model_out(c, 1'b0, 8'h10, 1'b0); m = care_mask(c, 1'b0);
            n_checks++;
            if ((obs & m) !== (e & m)) begin
                n_fail++; $display("FAIL syn_nolearn c=%0d got=%h exp=%h", c, obs & m, e & m);
            end
            if (c == 19) begin
                n_checks++;
                if (syn_addr !== 13'h0201 || neur_addr !== 8'h09 || neur_we !== 1'b0) begin
                    n_fail++; $display("FAIL rd_j9 got sa=%h na=%h we=%b exp sa=0201 na=09 we=0",
                                       syn_addr, neur_addr, neur_we);
                end
            end
            if (c == 20) begin
                n_checks++;
                if (neur_we !== 1'b1 || syn_we !== 1'b0) begin
                    n_fail++; $display("FAIL wr_j9 got nwe=%b swe=%b exp nwe=1 swe=0", neur_we, syn_we);
                end
            end
        end
        n_checks++;
        if (burst !== 1'b1) begin
            n_fail++; $display("FAIL burst_at_513 got=%b exp=1", burst);
        end
        tick();
        n_checks++;
        if ((obs & care_mask(0, 1'b0)) !== 30'h3) begin
            n_fail++; $display("FAIL syn_nolearn_ackw got=%h exp=%h", obs & care_mask(0, 1'b0), 30'h3);
        end
        req = 1'b0;
        tick();
        n_checks++;
        if ((obs & care_mask(0, 1'b0)) !== 30'h0) begin
            n_fail++; $display("FAIL syn_nolearn_release got=%h exp=%h", obs & care_mask(0, 1'b0), 30'h0);
        end
    endtask

    task automatic test_syn_learn();
        logic [29:0] e, m;
        int          we_cnt;
        we_cnt = 0;
        learn  = 1'b1;
        start_event(1'b0, 8'h10);
        for (int c = 1; c <= LAST_C; c++) begin
            tick();
            if (syn_we === 1'b1) we_cnt++;
            e = model_out(c, 1'b0, 8'h10, 1'b1); m = care_mask(c, 1'b0);
            n_checks++;
            if ((obs & m) !== (e & m)) begin
                n_fail++; $display("FAIL syn_learn c=%0d got=%h exp=%h", c, obs & m, e & m);
            end
            if (c == 16) begin
                n_checks++;
                if (syn_we !== 1'b1 || syn_cs !== 1'b1 || syn_addr !== 13'h0200) begin
                    n_fail++; $display("FAIL learn_wr_j7 got cs=%b we=%b sa=%h exp cs=1 we=1 sa=0200",
                                       syn_cs, syn_we, syn_addr);
                end
            end
        end
        n_checks++;
        if (we_cnt != 32) begin
            n_fail++; $display("FAIL learn_we_count got=%0d exp=32", we_cnt);
        end
        tick();
        req = 1'b0;
        tick();
        n_checks++;
        if ((obs & care_mask(0, 1'b0)) !== 30'h0) begin
            n_fail++; $display("FAIL syn_learn_release got=%h exp=%h", obs & care_mask(0, 1'b0), 30'h0);
        end
        learn = 1'b0;
    endtask

    task automatic test_tref();
        logic [29:0] e, m;
        logic [7:0]  p;
        int          tref_cnt, ev_cnt, scs_cnt;
        tref_cnt = 0; ev_cnt = 0; scs_cnt = 0;
        p     = 8'($urandom);
        learn = 1'b1;
        start_event(1'b1, p);
        for (int c = 1; c <= LAST_C; c++) begin
            tick();
            if (tref === 1'b1) tref_cnt++;
            if (ev !== 1'b0) ev_cnt++;
            if (syn_cs !== 1'b0) scs_cnt++;
            e = model_out(c, 1'b1, p, 1'b1); m = care_mask(c, 1'b1);
            n_checks++;
            if ((obs & m) !== (e & m)) begin
                n_fail++; $display("FAIL tref c=%0d got=%h exp=%h", c, obs & m, e & m);
            end
        end
        n_checks++;
        if (tref_cnt != 2 * N || ev_cnt != 0 || scs_cnt != 0) begin
            n_fail++; $display("FAIL tref_counts got tref=%0d ev=%0d scs=%0d exp tref=%0d ev=0 scs=0",
                               tref_cnt, ev_cnt, scs_cnt, 2 * N);
        end
        tick();
        req = 1'b0;
        tick();
        learn = 1'b0;
    endtask

    task automatic test_random();
        logic [29:0] e, m;
        bit          t, l;
        logic [7:0]  p;
        for (int k = 0; k < 4; k++) begin
            t = 1'($urandom); l = 1'($urandom); p = 8'($urandom);
            learn = l;
            start_event(t, p);
            for (int c = 1; c <= LAST_C; c++) begin
                tick();
                etype = 1'($urandom);
                eaddr = 8'($urandom);
                e = model_out(c, t, p, l); m = care_mask(c, t);
                n_checks++;
                if ((obs & m) !== (e & m)) begin
                    n_fail++; $display("FAIL random k=%0d c=%0d got=%h exp=%h", k, c, obs & m, e & m);
                end
            end
            tick();
            req = 1'b0;
            tick();
            n_checks++;
            if ((obs & care_mask(0, 1'b0)) !== 30'h0) begin
                n_fail++; $display("FAIL random_release k=%0d got=%h exp=0", k, obs & care_mask(0, 1'b0));
            end
        end
        learn = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [29:0] e, m;
        logic [7:0]  p2;
        start_event(1'b0, 8'h33);
        for (int c = 1; c <= LAST_C; c++) tick();
        for (int i = 0; i < 20; i++) begin
            tick();
            n_checks++;
            if ((obs & care_mask(0, 1'b0)) !== 30'h3) begin
                n_fail++; $display("FAIL hold_ack i=%0d got=%h exp=%h", i, obs & care_mask(0, 1'b0), 30'h3);
            end
        end
        req = 1'b0;
        tick();
        n_checks++;
        if (ack !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL ack_drop got ack=%b busy=%b exp ack=0 busy=0", ack, busy);
        end
        p2 = 8'($urandom);
        start_event(1'b0, p2);
        for (int c = 1; c <= LAST_C; c++) begin
            tick();
            e = model_out(c, 1'b0, p2, 1'b0); m = care_mask(c, 1'b0);
            n_checks++;
            if ((obs & m) !== (e & m)) begin
                n_fail++; $display("FAIL second_event c=%0d got=%h exp=%h", c, obs & m, e & m);
            end
        end
        tick();
        req = 1'b0;
        tick();
    endtask

    task automatic test_gate();
        gate = 1'b1;
        start_event(1'b0, 8'h05);
        for (int i = 0; i < 30; i++) begin
            tick();
            n_checks++;
            if ((obs & care_mask(0, 1'b0)) !== 30'h0) begin
                n_fail++; $display("FAIL gated i=%0d got=%h exp=0", i, obs & care_mask(0, 1'b0));
            end
        end
        req  = 1'b0;
        gate = 1'b0;
        tick();
    endtask

    task automatic test_gate_mid();
        logic [29:0] e, m;
        start_event(1'b0, 8'hA7);
        for (int c = 1; c <= LAST_C; c++) begin
            tick();
            if (c == 201) gate = 1'b1;
            e = model_out(c, 1'b0, 8'hA7, 1'b0); m = care_mask(c, 1'b0);
            n_checks++;
            if ((obs & m) !== (e & m)) begin
                n_fail++; $display("FAIL gate_mid c=%0d got=%h exp=%h", c, obs & m, e & m);
            end
        end
        tick();
        req = 1'b0;
        tick();
        req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if ((obs & care_mask(0, 1'b0)) !== 30'h0) begin
                n_fail++; $display("FAIL gate_after i=%0d got=%h exp=0", i, obs & care_mask(0, 1'b0));
            end
        end
        req  = 1'b0;
        gate = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        logic [29:0] e, m;
        start_event(1'b0, 8'h44);
        for (int c = 1; c <= 102; c++) tick();
        n_checks++;
        if (neur_we !== 1'b1 || neur_addr !== 8'd50) begin
            n_fail++; $display("FAIL pre_reset_wr50 got we=%b na=%0d exp we=1 na=50", neur_we, neur_addr);
        end
        rstn = 1'b0;
        tick();
        n_checks++;
        if (obs !== 30'h0) begin
            n_fail++; $display("FAIL reset_mid got=%h exp=0", obs);
        end
        rstn = 1'b1;
        req  = 1'b0;
        tick();
        n_checks++;
        if (obs !== 30'h0) begin
            n_fail++; $display("FAIL reset_mid_idle got=%h exp=0", obs);
        end
        start_event(1'b0, 8'h12);
        for (int c = 1; c <= LAST_C; c++) begin
            tick();
            e = model_out(c, 1'b0, 8'h12, 1'b0); m = care_mask(c, 1'b0);
            n_checks++;
            if ((obs & m) !== (e & m)) begin
                n_fail++; $display("FAIL after_reset c=%0d got=%h exp=%h", c, obs & m, e & m);
            end
        end
        tick();
        req = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_syn_nolearn();
        test_syn_learn();
        test_tref();
        test_random();
        test_back_to_back();
        test_gate();
        test_gate_mid();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/neur_event_sequencer.md
Name: neur_event_sequencer

Overview:
- Controller that sequences synaptic_core and neuron_core for one incoming event.
- Accepts a pre-synaptic or time-reference event over a 4-phase req/ack handshake.
- Sweeps all N post-synaptic neurons with a read/write pair of SRAM cycles per neuron, then pulses burst-end and acknowledges.
- Sits between the AER input front-end / scheduler and the two cores. Replaces hand-driven CTRL_* stimulus.

Parameters:
- N, 256, number of neurons.
- M, 8, log2(N); neuron address width.

Ports:
- CLK  in  1  clock.
- RSTN_syncn  in  1  synchronous active-low reset.
- SPI_GATE_ACTIVITY_sync  in  1  when 1, no new event accepted.
- SPI_LEARN_EN  in  1  enables synapse word write-back.
- EVT_REQ  in  1  event request, 4-phase.
- EVT_TYPE  in  1  0 = synaptic event, 1 = time-reference (tref) event.
- EVT_ADDR  in  M  pre-synaptic neuron address; ignored for tref.
- EVT_ACK  out  1  event acknowledge.
- CTRL_SYNARRAY_CS  out  1  synapse SRAM chip select.
- CTRL_SYNARRAY_WE  out  1  synapse SRAM write enable.
- CTRL_SYNARRAY_ADDR  out  2M-3  synapse word address.
- CTRL_NEURMEM_CS  out  1  neuron SRAM chip select.
- CTRL_NEURMEM_WE  out  1  neuron SRAM write enable.
- CTRL_NEURMEM_ADDR  out  M  neuron address.
- CTRL_NEUR_EVENT  out  1  synaptic update enable to neuron_core.
- CTRL_NEUR_TREF  out  1  time-reference update enable to neuron_core.
- CTRL_NEUR_BURST_END  out  1  one-cycle pulse at end of sweep.
- BUSY  out  1  high in any state other than IDLE.

Behaviour:
- All outputs are registered. On reset every output is 0, the FSM goes to IDLE and the neuron counter j = 0.
- Reset wins over any operation in progress: no further CS/WE is issued and ACK drops.
- FSM states are IDLE, RD, WR, DONE, ACKW.
- IDLE: if EVT_REQ=1 and SPI_GATE_ACTIVITY_sync=0 at an edge, latch EVT_TYPE and EVT_ADDR (pre), set j=0, go to RD. Otherwise stay in IDLE.
- RD (neuron j, one cycle):
  - NEURMEM_CS=1, NEURMEM_WE=0, NEURMEM_ADDR=j.
  - Synaptic event: SYNARRAY_CS=1, SYNARRAY_WE=0, SYNARRAY_ADDR={pre, j[M-1:3]}, NEUR_EVENT=1.
  - Tref event: SYNARRAY_CS=0, NEUR_TREF=1.
  - Next state is WR.
- WR (one cycle):
  - Same addresses and EVENT/TREF as RD, with NEURMEM_WE=1.
  - SYNARRAY_CS=WE=1 only when the event is synaptic, SPI_LEARN_EN=1 and j[2:0]=7 (last neuron of the 8-synapse word).
  - If j=N-1, go to DONE; otherwise j=j+1 and go to RD.
- DONE (one cycle): all CS/WE/EVENT/TREF low, BURST_END=1, EVT_ACK set to 1, go to ACKW.
- ACKW: hold EVT_ACK=1 until EVT_REQ=0 is sampled; then EVT_ACK=0 and go to IDLE. No new event is accepted in the same cycle.
- Latency: REQ sampled at edge k gives the first RD at cycle k+1 and DONE at cycle k+1+2N (k+513 for N=256).
- Gating raised mid-sweep: the current sweep completes; gating only blocks acceptance in IDLE.
- EVT_ADDR and EVT_TYPE changes after acceptance are ignored (latched copy is used).
- The counter j is M bits wide. The terminal compare is j==N-1; there is no wrap past N-1.
- CTRL_NEUR_EVENT and CTRL_NEUR_TREF are never high together.

Decomposition:
- Shared package odin_ctrl_pkg: state enum (IDLE, RD, WR, DONE, ACKW), EVT_SYN/EVT_TREF constants, and the width function SYNADDR_W = 2*M-3.
- One natural sub-module, aer_handshake_4ph: REQ sampling and ACK hold/release. The sweep FSM stays in the top module.

Test Plan:
- Synaptic event, EVT_ADDR=8'h10, learn off:
  - j=9 RD cycle: SYNARRAY_ADDR=13'h0201, NEURMEM_ADDR=8'h09, WE=0.
  - j=9 WR cycle: NEURMEM_WE=1, SYNARRAY_WE=0.
  - BURST_END at cycle 513 after acceptance.
- Same event with SPI_LEARN_EN=1: SYNARRAY_WE=1 exactly 32 times, at j=7,15,…,255. WR at j=8'h07 has SYNARRAY_ADDR=13'h0200.
- Tref event: SYNARRAY_CS=0 for the whole sweep, NEUR_TREF=1 for 512 cycles, NEUR_EVENT=0 throughout.
- Handshake: hold EVT_REQ 20 cycles past DONE.
  - ACK stays 1 until REQ falls, then drops one cycle later.
  - A second REQ held through this does not start a sweep until after IDLE.
- SPI_GATE_ACTIVITY_sync=1 with REQ high: no CS ever asserted, ACK=0. Raising gate at j=100 mid-sweep: sweep still reaches j=255 and ACKs.
- RSTN_syncn=0 at j=50 WR: next cycle all outputs 0, state IDLE. A new REQ after reset starts at j=0.
